// File: rtl/execute_stage_if.sv
// Signal bundle between the D/E register, the execute stage and the E/M boundary.
interface execute_stage_if #(
  parameter int unsigned WORD_SIZE = 32
);
  logic                 valid_in;
  logic [1:0]           instruction_type_in;
  logic [WORD_SIZE-1:0] pc_in;
  logic [6:0]           opcode_in;
  logic [6:0]           funct7_in;
  logic [2:0]           funct3_in;
  logic [WORD_SIZE-1:0] s1_in;
  logic [WORD_SIZE-1:0] s2_in;
  logic [WORD_SIZE-1:0] immediate_in;
  logic                 stall_in;
  logic                 stall_out;
  logic                 valid_out;
  logic [1:0]           instruction_type_out;
  logic [WORD_SIZE-1:0] pc_out;
  logic [2:0]           funct3_out;
  logic [WORD_SIZE-1:0] s2_out;
  logic [WORD_SIZE-1:0] result_out;

  modport master (
    output valid_in, instruction_type_in, pc_in, opcode_in, funct7_in,
           funct3_in, s1_in, s2_in, immediate_in, stall_in,
    input  stall_out, valid_out, instruction_type_out, pc_out, funct3_out,
           s2_out, result_out
  );

  modport slave (
    input  valid_in, instruction_type_in, pc_in, opcode_in, funct7_in,
           funct3_in, s1_in, s2_in, immediate_in, stall_in,
    output stall_out, valid_out, instruction_type_out, pc_out, funct3_out,
           s2_out, result_out
  );
endinterface

// File: rtl/execute_stage.sv
// RISC-V execute stage: single-cycle ALU plus a multi-cycle MUL that stalls D/E,
// with results registered into the E/M boundary.
module execute_stage #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned MUL_LATENCY = 4   // must be >= 2
) (
  input logic            clk,
  input logic            reset,
  execute_stage_if.slave bus
);
  localparam logic [6:0]       OPCODE_ALU     = 7'b0110011;
  localparam logic [6:0]       OPCODE_ALU_IMM = 7'b0010011;
  localparam logic [6:0]       MUL_FUNCT7     = 7'b0000001;
  localparam logic [6:0]       ALT_FUNCT7     = 7'b0100000;
  localparam int unsigned      SHW            = $clog2(WORD_SIZE);
  localparam int unsigned      CNT_W          = $clog2(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD       = CNT_W'(MUL_LATENCY - 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     count, count_next;
  logic                 capture;
  logic                 fsm_block;
  logic                 mul_done;

  logic                 is_alu, is_alu_imm, is_mul, alt;
  logic [WORD_SIZE-1:0] op_b;
  logic [SHW-1:0]       shamt;
  logic [WORD_SIZE-1:0] alu_result;
  logic [WORD_SIZE-1:0] mul_a, mul_b, product;

  logic                 valid_q;
  logic [1:0]           itype_q;
  logic [WORD_SIZE-1:0] pc_q, s2_q, result_q;
  logic [2:0]           funct3_q;

  always_comb begin
    is_alu     = (bus.opcode_in == OPCODE_ALU);
    is_alu_imm = (bus.opcode_in == OPCODE_ALU_IMM);
    is_mul     = is_alu && (bus.funct7_in == MUL_FUNCT7);
    alt        = (bus.funct7_in == ALT_FUNCT7);
    op_b       = is_alu_imm ? bus.immediate_in : bus.s2_in;
    shamt      = op_b[SHW-1:0];
    alu_result = '0;
    if (is_alu || is_alu_imm) begin
      case (bus.funct3_in)
        3'b000:  alu_result = (is_alu && alt) ? bus.s1_in - op_b : bus.s1_in + op_b;
        3'b001:  alu_result = bus.s1_in << shamt;
        3'b010:  alu_result = {{(WORD_SIZE-1){1'b0}}, $signed(bus.s1_in) < $signed(op_b)};
        3'b011:  alu_result = {{(WORD_SIZE-1){1'b0}}, bus.s1_in < op_b};
        3'b100:  alu_result = bus.s1_in ^ op_b;
        3'b101:  alu_result = alt ? $unsigned($signed(bus.s1_in) >>> shamt)
                                  : bus.s1_in >> shamt;
        3'b110:  alu_result = bus.s1_in | op_b;
        default: alu_result = bus.s1_in & op_b;
      endcase
    end
  end

  assign product = mul_a * mul_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (capture) begin
        mul_a <= bus.s1_in;
        mul_b <= bus.s2_in;
      end
    end
  end

  // The busy count runs regardless of stall_in; only completion waits on downstream.
  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    fsm_block  = 1'b0;
    mul_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid_in && is_mul) begin
          state_next = MUL_BUSY;
          count_next = CNT_LOAD;
          capture    = 1'b1;
          fsm_block  = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (count != '0) begin
          count_next = count - 1'b1;
          fsm_block  = 1'b1;
        end else if (!bus.stall_in) begin
          state_next = IDLE;
          mul_done   = 1'b1;
        end else begin
          fsm_block  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.stall_out = reset & (bus.stall_in | fsm_block);

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      itype_q  <= '0;
      pc_q     <= '0;
      funct3_q <= '0;
      s2_q     <= '0;
      result_q <= '0;
    end else if (!bus.stall_in) begin
      if (fsm_block) begin
        valid_q <= 1'b0;
      end else begin
        valid_q  <= bus.valid_in;
        itype_q  <= bus.instruction_type_in;
        pc_q     <= bus.pc_in;
        funct3_q <= bus.funct3_in;
        s2_q     <= bus.s2_in;
        result_q <= mul_done ? product : alu_result;
      end
    end
  end

  assign bus.valid_out            = valid_q;
  assign bus.instruction_type_out = itype_q;
  assign bus.pc_out               = pc_q;
  assign bus.funct3_out           = funct3_q;
  assign bus.s2_out               = s2_q;
  assign bus.result_out           = result_q;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases, then random traffic against a
// transaction-level model of the stage (D/E register emulated by a queue).
module tb_execute_stage;
  localparam int unsigned W      = 32;
  localparam int unsigned LAT    = 4;
  localparam logic [6:0]  OP_ALU = 7'h33;
  localparam logic [6:0]  OP_IMM = 7'h13;

  typedef struct packed {
    logic         valid;
    logic [1:0]   itype;
    logic [31:0]  pc;
    logic [6:0]   opcode;
    logic [6:0]   funct7;
    logic [2:0]   funct3;
    logic [31:0]  s1;
    logic [31:0]  s2;
    logic [31:0]  imm;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_stage_if #(.WORD_SIZE(W)) bus ();
  execute_stage #(.WORD_SIZE(W), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  instr_t cur;
  instr_t q[$];
  bit     random_mode = 0;
  logic   last_stall;

  logic        e_valid;
  logic [1:0]  e_itype;
  logic [31:0] e_pc, e_s2, e_result;
  logic [2:0]  e_f3;
  bit          mul_on;
  int          mul_age;
  logic [31:0] mul_prod;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [6:0] op, input logic [6:0] f7,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] pc);
    instr_t i;
    i.valid = 1'b1; i.itype = 2'b01; i.pc = pc; i.opcode = op; i.funct7 = f7;
    i.funct3 = f3; i.s1 = a; i.s2 = b; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t bubble();
    instr_t i = '0;
    return i;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int unsigned r;
    i.valid  = ($urandom_range(0, 9) != 0);
    i.itype  = 2'($urandom);
    i.pc     = $urandom;
    i.funct3 = 3'($urandom);
    r = $urandom_range(0, 9);
    i.opcode = (r < 4) ? OP_ALU : (r < 8) ? OP_IMM : 7'($urandom);
    r = $urandom_range(0, 3);
    i.funct7 = (r == 0) ? 7'h20 : (r == 1) ? 7'h01 : (r == 2) ? 7'h00 : 7'($urandom);
    i.s1  = pick();
    i.s2  = pick();
    i.imm = pick();
    return i;
  endfunction

  function automatic instr_t next_queued();
    if (q.size() > 0) return q.pop_front();
    return bubble();
  endfunction

  function automatic bit is_mul(input instr_t i);
    return i.valid && i.opcode == OP_ALU && i.funct7 == 7'h01;
  endfunction

  // Architectural result of one instruction, straight from the ISA rules.
  function automatic logic [31:0] ref_result(input instr_t i);
    logic [31:0] b = (i.opcode == OP_IMM) ? i.imm : i.s2;
    int unsigned sh = int'(b[4:0]);
    longint unsigned p;
    logic [63:0] p64;
    if (i.opcode != OP_ALU && i.opcode != OP_IMM) return 32'h0;
    if (i.opcode == OP_ALU && i.funct7 == 7'h01) begin
      p = longint'(i.s1) * longint'(i.s2);
      p64 = p;
      return p64[31:0];
    end
    case (i.funct3)
      3'd0: return (i.opcode == OP_ALU && i.funct7 == 7'h20) ? i.s1 - b : i.s1 + b;
      3'd1: return i.s1 << sh;
      3'd2: return (signed'(i.s1) < signed'(b)) ? 32'd1 : 32'd0;
      3'd3: return (i.s1 < b) ? 32'd1 : 32'd0;
      3'd4: return i.s1 ^ b;
      3'd5: return (i.funct7 == 7'h20) ? 32'(signed'(i.s1) >>> sh) : i.s1 >> sh;
      3'd6: return i.s1 | b;
      default: return i.s1 & b;
    endcase
  endfunction

  // A MUL occupies the stage for LAT cycles from acceptance, then waits for downstream.
  function automatic logic model_stall(input logic st);
    if (!rst_n) return 1'b0;
    if (mul_on) return (mul_age < int'(LAT)) || st;
    if (is_mul(cur)) return 1'b1;
    return st;
  endfunction

  task automatic model_load(input logic [31:0] res);
    e_valid = cur.valid; e_itype = cur.itype; e_pc = cur.pc;
    e_f3 = cur.funct3; e_s2 = cur.s2; e_result = res;
  endtask

  task automatic model_edge(input logic st);
    if (!rst_n) begin
      e_valid = 0; e_itype = 0; e_pc = 0; e_f3 = 0; e_s2 = 0; e_result = 0;
      mul_on = 0; mul_age = 0;
    end else if (mul_on) begin
      if (mul_age >= int'(LAT) && !st) begin
        model_load(mul_prod);
        mul_on = 0;
      end else begin
        mul_age++;
        if (!st) e_valid = 0;
      end
    end else if (is_mul(cur)) begin
      mul_on = 1; mul_age = 1; mul_prod = ref_result(cur);
      if (!st) e_valid = 0;
    end else if (!st) begin
      model_load(ref_result(cur));
    end
  endtask

  task automatic cycle(input logic st);
    logic seen;
    bus.valid_in = cur.valid; bus.instruction_type_in = cur.itype; bus.pc_in = cur.pc;
    bus.opcode_in = cur.opcode; bus.funct7_in = cur.funct7; bus.funct3_in = cur.funct3;
    bus.s1_in = cur.s1; bus.s2_in = cur.s2; bus.immediate_in = cur.imm;
    bus.stall_in = st;
    #2;
    seen = bus.stall_out;
    check("stall_out", {31'b0, seen}, {31'b0, model_stall(st)});
    @(posedge clk);
    model_edge(st);
    if (rst_n && !seen) cur = random_mode ? rand_instr() : next_queued();
    last_stall = seen;
    #1;
    check("valid_out", {31'b0, bus.valid_out}, {31'b0, e_valid});
    if (e_valid) begin
      check("itype_out", {30'b0, bus.instruction_type_out}, {30'b0, e_itype});
      check("pc_out", bus.pc_out, e_pc);
      check("funct3_out", {29'b0, bus.funct3_out}, {29'b0, e_f3});
      check("s2_out", bus.s2_out, e_s2);
      check("result_out", bus.result_out, e_result);
    end
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n = 1'b0;
    repeat (n) cycle(random_mode ? 1'($urandom_range(0, 1)) : 1'b0);
    rst_n = 1'b1;
    cur = random_mode ? rand_instr() : bubble();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'b0, bus.valid_out}, 32'h0);
    check({tag, "_itype"}, {30'b0, bus.instruction_type_out}, 32'h0);
    check({tag, "_pc"}, bus.pc_out, 32'h0);
    check({tag, "_funct3"}, {29'b0, bus.funct3_out}, 32'h0);
    check({tag, "_s2"}, bus.s2_out, 32'h0);
    check({tag, "_result"}, bus.result_out, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, st_cnt;
    bit done;
    mul_on = 0; mul_age = 0;

    // Reset held with a valid ADD presented
    cur = mk(OP_ALU, 7'h00, 3'd0, 32'd5, 32'd9, 32'd0, 32'h40);
    do_reset(2);
    check_all_zero("reset");
    check("reset_stall", {31'b0, last_stall}, 32'h0);

    // Single-cycle ops and edge cases
    q.push_back(mk(OP_ALU, 7'h00, 3'd0, 32'd23, 32'd7, 32'd0, 32'h100));
    q.push_back(mk(OP_IMM, 7'h00, 3'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h104));
    q.push_back(mk(OP_ALU, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 32'd0, 32'h108));
    q.push_back(mk(OP_ALU, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10C));
    q.push_back(mk(OP_ALU, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h110));
    q.push_back(mk(OP_ALU, 7'h01, 3'd0, 32'd6, 32'd7, 32'd0, 32'h114));
    cycle(1'b0);
    cycle(1'b0);
    check("add_result", bus.result_out, 32'd30);
    check("add_valid", {31'b0, bus.valid_out}, 32'd1);
    check("add_pc", bus.pc_out, 32'h100);
    cycle(1'b0); check("addi_wrap", bus.result_out, 32'h0);
    cycle(1'b0); check("sra", bus.result_out, 32'hF800_0000);
    cycle(1'b0); check("slt", bus.result_out, 32'd1);
    cycle(1'b0); check("sltu", bus.result_out, 32'd0);

    // MUL 6*7: stall count and latency
    n = 0; st_cnt = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(1'b0);
      n++;
      if (last_stall) st_cnt++;
      if (bus.valid_out && bus.result_out == 32'd42) done = 1;
    end
    check("mul_done", {31'b0, done}, 32'd1);
    check("mul_latency", n, LAT + 1);
    check("mul_stall_cycles", st_cnt, LAT);

    // MUL held at completion by downstream stall
    q.push_back(mk(OP_ALU, 7'h01, 3'd3, 32'd6, 32'd7, 32'd0, 32'h200));
    cycle(1'b0);
    repeat (LAT) cycle(1'b0);
    st_cnt = 0;
    repeat (3) begin
      cycle(1'b1);
      if (last_stall) st_cnt++;
    end
    check("hold_stall_cycles", st_cnt, 32'd3);
    check("hold_valid", {31'b0, bus.valid_out}, 32'd0);
    cycle(1'b0);
    check("hold_release_stall", {31'b0, last_stall}, 32'd0);
    check("hold_result", bus.result_out, 32'd42);
    check("hold_valid_after", {31'b0, bus.valid_out}, 32'd1);
    check("hold_pc", bus.pc_out, 32'h200);

    // Reset during the second busy cycle of a MUL
    q.push_back(mk(OP_ALU, 7'h01, 3'd0, 32'd6, 32'd7, 32'd0, 32'h300));
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    do_reset(1);
    check("midmul_valid", {31'b0, bus.valid_out}, 32'd0);
    check("midmul_result", bus.result_out, 32'd0);
    q.push_back(mk(OP_ALU, 7'h00, 3'd0, 32'd1, 32'd2, 32'd0, 32'h400));
    cycle(1'b0);
    check("midmul_idle", {31'b0, last_stall}, 32'd0);
    cycle(1'b0);
    check("post_reset_add", bus.result_out, 32'd3);
    check("post_reset_valid", {31'b0, bus.valid_out}, 32'd1);

    // Random traffic with random downstream stalls and occasional resets
    random_mode = 1;
    cur = rand_instr();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
      else cycle(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the in-order RISC-V pipeline. Sits directly downstream of the D/E pipeline register and consumes its outputs.
- Computes the ALU result for register-register (`OPCODE_ALU`) and register-immediate (`OPCODE_ALU_IMM`) instructions.
- Runs a multi-cycle multiplier FSM for MUL and drives a stall back to the D/E register while busy.
- Registers its results into the E/M boundary, held when downstream stalls.

Parameters:
- WORD_SIZE, `WORD_SIZE` (32): datapath width.
- MUL_LATENCY, 4: cycles `stall_out` is asserted for an unstalled MUL; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- valid_in  in  1  D/E holds a valid instruction.
- instruction_type_in  in  2  passed through.
- pc_in  in  WORD_SIZE  passed through.
- opcode_in  in  7  instruction opcode.
- funct7_in  in  7  instruction funct7.
- funct3_in  in  3  instruction funct3.
- s1_in  in  WORD_SIZE  source operand 1.
- s2_in  in  WORD_SIZE  source operand 2; also store data.
- immediate_in  in  WORD_SIZE  sign-extended immediate.
- stall_in  in  1  downstream (E/M) cannot accept.
- stall_out  out  1  to D/E stall input; D/E holds its contents while high.
- valid_out  out  1  result register holds a valid instruction.
- instruction_type_out  out  2  registered.
- pc_out  out  WORD_SIZE  registered.
- funct3_out  out  3  registered.
- s2_out  out  WORD_SIZE  registered store data.
- result_out  out  WORD_SIZE  registered ALU/MUL result.

Behaviour:
- Reset (reset==0 at posedge):
  - All outputs and output registers clear to 0.
  - FSM goes to IDLE and the multiplier counter clears.
  - Reset overrides everything, including an in-flight MUL, which is discarded.
- Operand B: `immediate_in` when `opcode_in==OPCODE_ALU_IMM`, else `s2_in`.
- Operations (funct3):
  - 000: ADD; SUB when `OPCODE_ALU` and funct7=0100000.
  - 001: SLL by B[4:0].
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL; SRA when funct7=0100000.
  - 110: OR.
  - 111: AND.
  - All arithmetic is modulo 2^WORD_SIZE.
- MUL:
  - Decoded when `opcode_in==OPCODE_ALU` and `funct7_in==MUL_FUNCT7` (0000001), any funct3.
  - Produces the low WORD_SIZE bits of s1*s2, treated as unsigned.
- Unknown opcode: result 0, still passed down with the input valid.
- FSM states: IDLE, MUL_BUSY.
  - IDLE with valid MUL: capture s1/s2, load counter=MUL_LATENCY-1, go to MUL_BUSY. `stall_out`=1 this cycle.
  - MUL_BUSY, counter!=0: decrement every cycle, independent of `stall_in`. `stall_out`=1.
  - MUL_BUSY, counter==0, `stall_in`==0: write the product to the output registers, return to IDLE. `stall_out`=0 this cycle, so D/E advances.
  - MUL_BUSY, counter==0, `stall_in`==1: hold in MUL_BUSY with `stall_out`=1.
- `stall_out` equation: `stall_in` | (IDLE & valid_in & is_mul) | (MUL_BUSY & !(count==0 & !stall_in)).
- Output register update rule:
  - Loads on every posedge where reset is high and `stall_in`==0 and the FSM does not block.
  - `valid_out` <= `valid_in` on a load.
  - `valid_out` <= 0 while the FSM is busy (bubble) and `stall_in`==0.
  - With `stall_in`==1 all outputs hold.
- Latency:
  - Single-cycle op: 1 cycle from D/E output to `valid_out`.
  - MUL: MUL_LATENCY+1 cycles.
  - `stall_out` is high for exactly MUL_LATENCY cycles when `stall_in` is low.
- Non-MUL instructions never assert `stall_out` except by pass-through of `stall_in`.
- Back-to-back MULs: the second starts in the cycle after the first completes; there are no idle gaps beyond the FSM latency.
- `valid_in`==0: no FSM transition; the result register loads a bubble (`valid_out`=0).

Test Plan:
- Reset: hold reset=0 for 2 cycles with valid ADD inputs -> every output 0, `stall_out`=0.
- Single-cycle ADD: s1=23, s2=7, ADD, valid=1, stall_in=0 -> next posedge `result_out`=30, `valid_out`=1, `pc_out`=`pc_in`, `stall_out` never high.
- ALU_IMM + edge ops:
  - ADDI s1=0xFFFFFFFF, imm=1 -> `result_out`=0 (wrap).
  - SRA of 0x80000000 by 4 -> 0xF8000000.
  - SLT -1<1 -> 1; SLTU -1<1 -> 0.
- MUL: s1=6, s2=7 -> `stall_out` high exactly 4 cycles; `valid_out`=1 with `result_out`=42 at cycle 5; bubbles (`valid_out`=0) in between.
- MUL with downstream stall: assert `stall_in` in MUL_BUSY at count==0 for 3 cycles -> `stall_out` stays high, outputs held; after release, result 42 appears one cycle later.
- Reset mid-MUL: assert reset in the 2nd busy cycle -> FSM IDLE, `valid_out`=0; a subsequent ADD 1+2 gives 3 after 1 cycle.
